// File: rtl/cnn_out_pkg.sv
// Shared definitions for the CNN output frame writer.
//   state_t  : frame writer FSM states (IDLE, ACTIVE, DRAIN, DONE)
//   W_ENTRY  : FIFO entry width for the default geometry (pixel + word offset)
package cnn_out_pkg;

    localparam int unsigned W_DATA_DEF       = 32;
    localparam int unsigned W_WORD_DEF       = 14;
    localparam int unsigned W_FRAME_SIZE_DEF = 25;
    localparam int unsigned W_ENTRY          = W_DATA_DEF + W_WORD_DEF;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/cnn_out_frame_writer_sync_fifo.sv
// sync_fifo: single-clock FIFO with registered full/empty flags.
//   clk, rst      : clock, asynchronous active-high reset
//   push, din     : write request and data (accepted when not full, or when
//                   a pop happens in the same cycle)
//   pop, dout     : read request and head-of-queue data (ignored when empty)
//   full, empty   : registered status flags
//   count         : registered occupancy
module sync_fifo #(
    parameter int unsigned WIDTH = 46,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [AW:0]      count_next;

    assign do_pop  = pop & ~empty;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr];

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + 1'b1;
        end else if (!do_push && do_pop) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            count  <= count_next;
            full   <= (count_next == FULL_CNT);
            empty  <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/cnn_out_frame_writer.sv
// cnn_out_frame_writer: captures one CNN output frame into shared SRAM.
//   HCLK, HRESET          : clock, asynchronous active-high reset
//   start, base_addr,
//   frame_size            : arm one frame; address/size latched on start
//   in_pixel, in_valid    : accelerator output stream (no backpressure)
//   sram_req, sram_gnt    : SRAM port arbitration
//   sram_en, sram_we,
//   sram_addr, sram_wdata : registered SRAM write port
//   busy                  : capturing or draining
//   frame_done            : one-cycle pulse with the final write
//   done_status, overflow : sticky status, cleared by start
//   pix_count             : pixels seen this frame (accepted or dropped)
module cnn_out_frame_writer
    import cnn_out_pkg::*;
#(
    parameter int unsigned W_DATA       = W_DATA_DEF,
    parameter int unsigned W_WORD       = W_WORD_DEF,
    parameter int unsigned W_FRAME_SIZE = W_FRAME_SIZE_DEF,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    start,
    input  logic [W_WORD-1:0]       base_addr,
    input  logic [W_FRAME_SIZE-1:0] frame_size,
    input  logic [W_DATA-1:0]       in_pixel,
    input  logic                    in_valid,
    output logic                    sram_req,
    input  logic                    sram_gnt,
    output logic                    sram_en,
    output logic                    sram_we,
    output logic [W_WORD-1:0]       sram_addr,
    output logic [W_DATA-1:0]       sram_wdata,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    done_status,
    output logic                    overflow,
    output logic [W_FRAME_SIZE-1:0] pix_count
);

    localparam int unsigned EW = W_DATA + W_WORD;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    state_t                  state;
    logic [W_WORD-1:0]       base;
    logic [W_FRAME_SIZE-1:0] fsize;

    logic [EW-1:0] push_entry;
    logic [EW-1:0] head;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    logic take;
    logic push_ok;
    logic pop;
    logic last_pixel;
    logic empty_next;

    assign busy     = (state == S_ACTIVE) || (state == S_DRAIN);
    assign sram_req = busy & ~fifo_empty;
    assign pop      = sram_req & sram_gnt;

    assign take       = (state == S_ACTIVE) & in_valid;
    assign push_ok    = take & (~fifo_full | pop);
    assign last_pixel = take & ((pix_count + 1'b1) == fsize);
    assign push_entry = {pix_count[W_WORD-1:0], in_pixel};

    // FIFO is empty after this edge: nothing pushed and either nothing held
    // or the only entry leaves now. Used so frame_done lines up with the
    // final sram_en instead of trailing it by a cycle.
    assign empty_next = ~push_ok & (fifo_count == CW'(pop));

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (HCLK),
        .rst   (HRESET),
        .push  (push_ok),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state       <= S_IDLE;
            base        <= '0;
            fsize       <= '0;
            pix_count   <= '0;
            overflow    <= 1'b0;
            done_status <= 1'b0;
            frame_done  <= 1'b0;
            sram_en     <= 1'b0;
            sram_we     <= 1'b0;
            sram_addr   <= '0;
            sram_wdata  <= '0;
        end else begin
            frame_done <= 1'b0;
            sram_en    <= pop;
            sram_we    <= pop;
            if (pop) begin
                sram_addr  <= base + head[EW-1:W_DATA];
                sram_wdata <= head[W_DATA-1:0];
            end
            if (frame_done) begin
                done_status <= 1'b1;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        base        <= base_addr;
                        fsize       <= frame_size;
                        pix_count   <= '0;
                        overflow    <= 1'b0;
                        done_status <= 1'b0;
                        if (frame_size == '0) begin
                            state      <= S_DONE;
                            frame_done <= 1'b1;
                        end else begin
                            state <= S_ACTIVE;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (in_valid) begin
                        pix_count <= pix_count + 1'b1;
                        if (!push_ok) begin
                            overflow <= 1'b1;
                        end
                        if (last_pixel) begin
                            if (empty_next) begin
                                state      <= S_DONE;
                                frame_done <= 1'b1;
                            end else begin
                                state <= S_DRAIN;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (empty_next) begin
                        state      <= S_DONE;
                        frame_done <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_out_frame_writer.sv
module tb_cnn_out_frame_writer;

    localparam int unsigned DEPTH = 16;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic        start = 1'b0;
    logic [13:0] base_addr = '0;
    logic [24:0] frame_size = '0;
    logic [31:0] in_pixel = '0;
    logic        in_valid = 1'b0;
    logic        sram_req;
    logic        sram_gnt = 1'b0;
    logic        sram_en;
    logic        sram_we;
    logic [13:0] sram_addr;
    logic [31:0] sram_wdata;
    logic        busy;
    logic        frame_done;
    logic        done_status;
    logic        overflow;
    logic [24:0] pix_count;

    cnn_out_frame_writer #(
        .W_DATA       (32),
        .W_WORD       (14),
        .W_FRAME_SIZE (25),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .start       (start),
        .base_addr   (base_addr),
        .frame_size  (frame_size),
        .in_pixel    (in_pixel),
        .in_valid    (in_valid),
        .sram_req    (sram_req),
        .sram_gnt    (sram_gnt),
        .sram_en     (sram_en),
        .sram_we     (sram_we),
        .sram_addr   (sram_addr),
        .sram_wdata  (sram_wdata),
        .busy        (busy),
        .frame_done  (frame_done),
        .done_status (done_status),
        .overflow    (overflow),
        .pix_count   (pix_count)
    );

    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int nwrites = 0;

    // Reference model: frame phase, buffered pixels, expected outputs.
    localparam int M_IDLE = 0, M_CAP = 1, M_DRN = 2, M_FIN = 3;
    typedef struct { logic [13:0] off; logic [31:0] data; } ent_t;
    typedef struct { logic [13:0] addr; logic [31:0] data; int when; } wr_t;
    int          ph = M_IDLE;
    ent_t        mq[$];
    wr_t         wq[$];
    int          dq[$];
    int unsigned mcnt = 0;
    int unsigned mfs = 0;
    logic [13:0] mbase = '0;
    bit          movf = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_step(input bit st, input bit iv, input logic [31:0] px, input bit g);
        int   occ0;
        bit   popped;
        ent_t e;
        wr_t  w;
        occ0   = mq.size();
        popped = (ph == M_CAP || ph == M_DRN) && occ0 > 0 && g;
        if (popped) begin
            e      = mq.pop_front();
            w.addr = mbase + e.off;
            w.data = e.data;
            w.when = cyc + 1;
            wq.push_back(w);
        end
        if (ph == M_CAP && iv) begin
            if (occ0 < DEPTH || popped) begin
                e.off  = mcnt[13:0];
                e.data = px;
                mq.push_back(e);
            end else begin
                movf = 1;
            end
            mcnt++;
            if (mcnt == mfs) ph = M_DRN;
        end
        if (ph == M_DRN && mq.size() == 0) begin
            ph = M_FIN;
            dq.push_back(cyc + 1);
        end
        if (st && (ph == M_IDLE || ph == M_FIN)) begin
            mbase = base_addr;
            mfs   = frame_size;
            mcnt  = 0;
            movf  = 0;
            if (frame_size == 0) begin
                ph = M_FIN;
                dq.push_back(cyc + 1);
            end else begin
                ph = M_CAP;
            end
        end
    endtask

    task automatic step(input bit st, input bit iv, input logic [31:0] px, input bit g);
        start    = st;
        in_valid = iv;
        in_pixel = px;
        sram_gnt = g;
        model_step(st, iv, px, g);
        @(posedge HCLK);
        #1;
    endtask

    task automatic start_frame(input logic [13:0] ba, input int unsigned fs, input bit g);
        base_addr  = ba;
        frame_size = fs[24:0];
        step(1, 0, '0, g);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!(ph == M_FIN && wq.size() == 0 && dq.size() == 0) && n < 200) begin
            step(0, 0, '0, 1);
            n++;
        end
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);
        chk({name, "_complete"}, (ph == M_FIN && wq.size() == 0 && dq.size() == 0), 1);
    endtask

    task automatic chk_idle_outputs(input string name);
        chk({name, "_ctl"}, {sram_req, sram_en, sram_we, busy, frame_done, done_status, overflow}, '0);
        chk({name, "_addr"}, sram_addr, 0);
        chk({name, "_wdata"}, sram_wdata, 0);
        chk({name, "_pixcnt"}, pix_count, 0);
    endtask

    task automatic chk_end(input string name, input int unsigned fs);
        chk({name, "_pixcnt"}, pix_count, fs);
        chk({name, "_ovf"}, overflow, movf);
        chk({name, "_done_st"}, done_status, 1);
        chk({name, "_busy"}, busy, 0);
    endtask

    // Monitor: pops expected writes / done pulses as the DUT presents them.
    always @(negedge HCLK) begin
        if (!HRESET) begin
            if (sram_en) begin
                nwrites++;
                if (wq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL write_unexpected: got addr 0x%0h data 0x%0h expected no write", sram_addr, sram_wdata);
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("write_addr", sram_addr, w.addr);
                    chk("write_data", sram_wdata, w.data);
                    chk("write_we", sram_we, 1);
                    chk("write_cycle", cyc, w.when);
                end
            end
            if (frame_done) begin
                if (dq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL done_unexpected: got frame_done=1 at cycle %0d expected 0", cyc);
                end else begin
                    chk("done_cycle", cyc, dq.pop_front());
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int unsigned fs;

        repeat (3) @(posedge HCLK);
        #1;
        chk_idle_outputs("reset");
        HRESET = 1'b0;
        step(0, 0, '0, 0);
        chk_idle_outputs("post_reset");

        // Nominal frame plus trailing in_valid beyond the frame size.
        w0 = nwrites;
        start_frame(14'h100, 64, 1);
        chk("nom_busy", busy, 1);
        for (int i = 0; i < 64; i++) step(0, 1, i, 1);
        for (int i = 0; i < 5; i++) step(0, 1, 32'hDEAD_0000 + i, 1);
        wait_done("nom");
        chk("nom_writes", nwrites - w0, 64);
        chk_end("nom", 64);

        // Grant withheld for the first 30 pixels: 16 buffered, 14 dropped.
        w0 = nwrites;
        start_frame(14'h0200, 40, 0);
        for (int i = 0; i < 40; i++) step(0, 1, $urandom, i >= 30);
        wait_done("bp");
        chk("bp_writes", nwrites - w0, 26);
        chk("bp_ovf_set", overflow, 1);
        chk_end("bp", 40);

        // FIFO filled, then push and pop together while full: no drop.
        w0 = nwrites;
        start_frame(14'h0400, 40, 0);
        for (int i = 0; i < 40; i++) step(0, 1, $urandom, i >= 16);
        wait_done("full_pp");
        chk("full_pp_writes", nwrites - w0, 40);
        chk("full_pp_ovf", overflow, 0);
        chk_end("full_pp", 40);

        // Zero-length frame.
        w0 = nwrites;
        start_frame(14'h0123, 0, 1);
        wait_done("zero");
        chk("zero_writes", nwrites - w0, 0);
        chk_end("zero", 0);

        // Address wrap at the top of the word space.
        w0 = nwrites;
        start_frame(14'h3FFE, 4, 1);
        for (int i = 0; i < 4; i++) step(0, 1, $urandom, 1);
        wait_done("wrap");
        chk("wrap_writes", nwrites - w0, 4);
        chk_end("wrap", 4);

        // A second start while capturing must not disturb the frame.
        start_frame(14'h0800, 10, 1);
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                base_addr  = 14'h2000;
                frame_size = 3;
                step(1, 1, $urandom, 1);
            end else begin
                step(0, 1, $urandom, 1);
            end
        end
        wait_done("restart_ign");
        chk_end("restart_ign", 10);

        // Random frames with random gaps and grant.
        for (int f = 0; f < 6; f++) begin
            int n = 0;
            fs = $urandom_range(1, 48);
            start_frame(14'($urandom), fs, 1);
            while (mcnt < fs && n < 1000) begin
                step(0, $urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0);
                n++;
            end
            wait_done("rand");
            chk_end("rand", fs);
        end

        // Reset while draining, with a write in flight.
        start_frame(14'h0300, 20, 0);
        for (int i = 0; i < 20; i++) step(0, 1, $urandom, 0);
        chk("drain_busy", busy, 1);
        step(0, 0, '0, 1);
        step(0, 0, '0, 1);
        HRESET = 1'b1;
        #1;
        chk_idle_outputs("mid_reset");
        ph = M_IDLE;
        mq.delete();
        wq.delete();
        dq.delete();
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        chk_idle_outputs("after_reset");

        w0 = nwrites;
        start_frame(14'h0500, 12, 1);
        for (int i = 0; i < 12; i++) step(0, 1, $urandom, 1);
        wait_done("post_rst");
        chk("post_rst_writes", nwrites - w0, 12);
        chk_end("post_rst", 12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
